// File: rtl/decode_stage.sv
// MIPS ID stage: register file with WB bypass, main control decode, immediate
// sign-extension, load-use stall detection and the registered ID/EX word.
module decode_stage (
    input  logic         clk,
    input  logic         rst,
    input  logic [63:0]  in_IF_ID,
    input  logic         in_regWrite,
    input  logic [4:0]   in_write_rd,
    input  logic [31:0]  in_writeData,
    input  logic         in_flush,
    output logic [146:0] out_ID_EX,
    output logic         out_stall
);

    logic [31:0] regs [32];

    logic [31:0] instr;
    logic [31:0] pc4;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm_ext;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        wb_en;
    logic        reads_rt;
    logic [8:0]  ctrl;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;

    assign instr   = in_IF_ID[31:0];
    assign pc4     = in_IF_ID[63:32];
    assign op      = instr[31:26];
    assign rs      = instr[25:21];
    assign rt      = instr[20:16];
    assign rd      = instr[15:11];
    assign imm_ext = {{16{instr[15]}}, instr[15:0]};
    assign wb_en   = in_regWrite && (in_write_rd != '0);

    // Control word layout: {ALUOp[1:0], RegDst, ALUSrc, Branch, MemWrite, MemRead, MemtoReg, RegWrite}
    always_comb begin
        ctrl     = '0;
        reads_rt = 1'b0;
        case (op)
            6'b000000: begin ctrl = 9'b10_1_0_000_0_1; reads_rt = 1'b1; end
            6'b100011: ctrl = 9'b00_0_1_001_1_1;
            6'b101011: begin ctrl = 9'b00_0_1_010_0_0; reads_rt = 1'b1; end
            6'b000100: begin ctrl = 9'b01_0_0_100_0_0; reads_rt = 1'b1; end
            6'b001000: ctrl = 9'b00_0_1_000_0_1;
            default:   ctrl = '0;
        endcase
    end

    // Same-cycle WB write is forwarded so the new value lands in ID/EX on this edge.
    always_comb begin
        rs_data = regs[rs];
        if (rs == '0)
            rs_data = '0;
        else if (wb_en && (in_write_rd == rs))
            rs_data = in_writeData;
    end

    always_comb begin
        rt_data = regs[rt];
        if (rt == '0)
            rt_data = '0;
        else if (wb_en && (in_write_rd == rt))
            rt_data = in_writeData;
    end

    assign ex_mem_read = out_ID_EX[2];
    assign ex_rt       = out_ID_EX[141:137];

    // Flush wins over stall so fetch is free to redirect.
    assign out_stall = !in_flush && ex_mem_read && (ex_rt != '0) &&
                       ((ex_rt == rs) || (reads_rt && (ex_rt == rt)));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++)
                regs[i] <= '0;
        end else if (wb_en) begin
            regs[in_write_rd] <= in_writeData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_ID_EX <= '0;
        end else begin
            out_ID_EX <= {rd, rt, imm_ext, rt_data, rs_data, pc4, ctrl};
            if (in_flush || out_stall)
                out_ID_EX[8:0] <= '0;
        end
    end

endmodule
